axil_mmio_slave: RTL and testbench

AXIL_MMIO_SLAVE -- requirements
Module: axil_mmio_slave

---
 rtl/axil_pkg.sv | 19 +
 rtl/axil_hold_reg.sv | 38 +++
 rtl/axil_mmio_slave.sv | 259 +++++++++++++++++++++++++
 tb/tb_axil_mmio_slave.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared response codes and FSM state type for the AXI-Lite to MMIO bridge.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StRdReq,
        StWrResp,
        StRdResp
    } axil_state_e;

    function automatic logic [1:0] resp_from_err(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register; ready while empty and enabled, emptied by i_clr.
module axil_hold_reg
    import axil_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clr,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = i_en & ~r_valid;
    assign o_full  = r_valid;
    assign o_data  = r_data;

    // Clear only ever happens while full, so it cannot collide with a capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

endmodule

// File: rtl/axil_mmio_slave.sv
// AXI-Lite slave bridging to a single-outstanding MMIO request port.
// Optional request timeout enabled by defining AXIL_MMIO_TIMEOUT_EN.
module axil_mmio_slave
    import axil_pkg::*;
#(
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,

    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,

    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,

    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    output logic [1:0]                    S_AXI_BRESP,

    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,

    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,

    output logic                          mmio_req,
    output logic                          mmio_we,
    output logic [C_AXI_ADDR_WIDTH-1:0]   mmio_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]   mmio_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] mmio_wstrb,
    input  logic                          mmio_ready,
    input  logic                          mmio_err,
    input  logic [C_AXI_DATA_WIDTH-1:0]   mmio_rdata
);

    localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned WENT_W = C_AXI_DATA_WIDTH + STRB_W;

    axil_state_e                 r_state;
    logic                        r_rst_done;
    logic                        r_rd_prio;
    logic                        r_mmio_req;
    logic                        r_mmio_we;
    logic [C_AXI_ADDR_WIDTH-1:0] r_mmio_addr;
    logic [C_AXI_DATA_WIDTH-1:0] r_mmio_wdata;
    logic [STRB_W-1:0]           r_mmio_wstrb;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic                        r_rvalid;
    logic [1:0]                  r_rresp;
    logic [C_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                        w_aw_full;
    logic                        w_w_full;
    logic                        w_ar_full;
    logic [C_AXI_ADDR_WIDTH-1:0] w_aw_addr;
    logic [C_AXI_ADDR_WIDTH-1:0] w_ar_addr;
    logic [WENT_W-1:0]           w_w_in;
    logic [WENT_W-1:0]           w_w_ent;
    logic [C_AXI_DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]           w_wstrb;
    logic                        w_wr_done;
    logic                        w_rd_done;
    logic                        w_wr_elig;
    logic                        w_rd_elig;
    logic                        w_grant_wr;
    logic                        w_timeout;
    logic                        w_unused_prot;

    assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Readies stay low until the first clock edge after reset release.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    assign w_wr_done = (r_state == StWrResp) && S_AXI_BREADY;
    assign w_rd_done = (r_state == StRdResp) && S_AXI_RREADY;

    assign w_w_in  = {S_AXI_WDATA, S_AXI_WSTRB};
    assign w_wdata = w_w_ent[WENT_W-1:STRB_W];
    assign w_wstrb = w_w_ent[STRB_W-1:0];

    axil_hold_reg #(
        .WIDTH (C_AXI_ADDR_WIDTH)
    ) u_aw_hold (
        .i_clk   (S_AXI_ACLK),
        .i_rst_n (S_AXI_ARESETN),
        .i_en    (r_rst_done),
        .i_valid (S_AXI_AWVALID),
        .o_ready (S_AXI_AWREADY),
        .i_data  (S_AXI_AWADDR),
        .i_clr   (w_wr_done),
        .o_full  (w_aw_full),
        .o_data  (w_aw_addr)
    );

    axil_hold_reg #(
        .WIDTH (WENT_W)
    ) u_w_hold (
        .i_clk   (S_AXI_ACLK),
        .i_rst_n (S_AXI_ARESETN),
        .i_en    (r_rst_done),
        .i_valid (S_AXI_WVALID),
        .o_ready (S_AXI_WREADY),
        .i_data  (w_w_in),
        .i_clr   (w_wr_done),
        .o_full  (w_w_full),
        .o_data  (w_w_ent)
    );

    axil_hold_reg #(
        .WIDTH (C_AXI_ADDR_WIDTH)
    ) u_ar_hold (
        .i_clk   (S_AXI_ACLK),
        .i_rst_n (S_AXI_ARESETN),
        .i_en    (r_rst_done),
        .i_valid (S_AXI_ARVALID),
        .o_ready (S_AXI_ARREADY),
        .i_data  (S_AXI_ARADDR),
        .i_clr   (w_rd_done),
        .o_full  (w_ar_full),
        .o_data  (w_ar_addr)
    );

    assign w_wr_elig  = w_aw_full && w_w_full;
    assign w_rd_elig  = w_ar_full;
    assign w_grant_wr = w_wr_elig && !(w_rd_elig && r_rd_prio);

`ifdef AXIL_MMIO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = !mmio_ready && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StWrReq || r_state == StRdReq) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // The tie-break pointer only moves on contended grants, so back-to-back ties alternate.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state      <= StIdle;
            r_rd_prio    <= 1'b1;
            r_mmio_req   <= 1'b0;
            r_mmio_we    <= 1'b0;
            r_mmio_addr  <= '0;
            r_mmio_wdata <= '0;
            r_mmio_wstrb <= '0;
            r_bvalid     <= 1'b0;
            r_bresp      <= RESP_OKAY;
            r_rvalid     <= 1'b0;
            r_rresp      <= RESP_OKAY;
            r_rdata      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant_wr) begin
                        r_state      <= StWrReq;
                        r_mmio_req   <= 1'b1;
                        r_mmio_we    <= 1'b1;
                        r_mmio_addr  <= w_aw_addr;
                        r_mmio_wdata <= w_wdata;
                        r_mmio_wstrb <= w_wstrb;
                        if (w_rd_elig) begin
                            r_rd_prio <= 1'b1;
                        end
                    end else if (w_rd_elig) begin
                        r_state      <= StRdReq;
                        r_mmio_req   <= 1'b1;
                        r_mmio_we    <= 1'b0;
                        r_mmio_addr  <= w_ar_addr;
                        r_mmio_wdata <= '0;
                        r_mmio_wstrb <= '0;
                        if (w_wr_elig) begin
                            r_rd_prio <= 1'b0;
                        end
                    end
                end
                StWrReq: begin
                    if (mmio_ready || w_timeout) begin
                        r_state    <= StWrResp;
                        r_mmio_req <= 1'b0;
                        r_mmio_we  <= 1'b0;
                        r_bvalid   <= 1'b1;
                        r_bresp    <= mmio_ready ? resp_from_err(mmio_err) : RESP_SLVERR;
                    end
                end
                StRdReq: begin
                    if (mmio_ready || w_timeout) begin
                        r_state    <= StRdResp;
                        r_mmio_req <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rresp    <= mmio_ready ? resp_from_err(mmio_err) : RESP_SLVERR;
                        r_rdata    <= mmio_ready ? mmio_rdata : '0;
                    end
                end
                StWrResp: begin
                    if (S_AXI_BREADY) begin
                        r_state  <= StIdle;
                        r_bvalid <= 1'b0;
                        r_bresp  <= RESP_OKAY;
                    end
                end
                StRdResp: begin
                    if (S_AXI_RREADY) begin
                        r_state  <= StIdle;
                        r_rvalid <= 1'b0;
                        r_rresp  <= RESP_OKAY;
                        r_rdata  <= '0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign mmio_req     = r_mmio_req;
    assign mmio_we      = r_mmio_we;
    assign mmio_addr    = r_mmio_addr;
    assign mmio_wdata   = r_mmio_wdata;
    assign mmio_wstrb   = r_mmio_wstrb;
    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = r_rresp;
    assign S_AXI_RDATA  = r_rdata;

endmodule

// File: tb/tb_axil_mmio_slave.sv
// Self-checking bench for axil_mmio_slave: vector table plus hand-written corner sequences,
// with a request/response scoreboard and an MMIO responder model.
module tb_axil_mmio_slave;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          lead;
        int          wait_cyc;
        logic [31:0] rdata;
        bit          err;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        mmio_req, mmio_we, mmio_ready, mmio_err;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic [3:0]  mmio_wstrb;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_hs = 0;
    int          req_cyc = 0;
    int          req_len = 0;
    int          rises = 0;
    int          rsp_wait = 0;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;
    req_t        req_q[$];
    rsp_t        rsp_q[$];
    vec_t        vecs[6];

    always #5 clk = ~clk;

    axil_mmio_slave #(
        .C_AXI_ADDR_WIDTH (32),
        .C_AXI_DATA_WIDTH (32),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .mmio_req      (mmio_req),
        .mmio_we       (mmio_we),
        .mmio_addr     (mmio_addr),
        .mmio_wdata    (mmio_wdata),
        .mmio_wstrb    (mmio_wstrb),
        .mmio_ready    (mmio_ready),
        .mmio_err      (mmio_err),
        .mmio_rdata    (mmio_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [31:0] rd, input bit err);
        req_t q;
        rsp_t r;
        q.we    = wr;
        q.addr  = a;
        q.wdata = wr ? d : 32'h0;
        q.strb  = wr ? s : 4'h0;
        r.is_wr = wr;
        r.resp  = err ? 2'b10 : 2'b00;
        r.rdata = wr ? 32'h0 : rd;
        req_q.push_back(q);
        rsp_q.push_back(r);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // MMIO responder and request scoreboard: ready after rsp_wait cycles of mmio_req.
    initial begin
        bit   prev_req = 1'b0;
        int   hi_cnt = 0;
        req_t e;
        mmio_ready = 1'b0;
        mmio_err   = 1'b0;
        mmio_rdata = '0;
        forever begin
            @(negedge clk);
            if (mmio_req) begin
                if (!prev_req) begin
                    rises++;
                    req_cyc = cyc;
                    hi_cnt  = 0;
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 32'(req_q.size()), 1);
                    end else begin
                        e = req_q.pop_front();
                        chk("req_we", mmio_we, e.we);
                        chk("req_addr", mmio_addr, e.addr);
                        chk("req_wdata", mmio_wdata, e.wdata);
                        chk("req_wstrb", mmio_wstrb, e.strb);
                    end
                end else begin
                    hi_cnt++;
                end
                mmio_ready = (hi_cnt >= rsp_wait);
                mmio_err   = rsp_err;
                mmio_rdata = rsp_rdata;
            end else begin
                if (prev_req) req_len = hi_cnt + 1;
                mmio_ready = 1'b0;
                mmio_err   = 1'b0;
                mmio_rdata = '0;
            end
            prev_req = mmio_req;
        end
    end

    // lead > 0: W goes that many cycles before AW; lead < 0: AW goes first.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead);
        int aw_dly = (lead > 0) ? lead : 0;
        int w_dly  = (lead < 0) ? -lead : 0;
        bit aw_pend = 0, w_pend = 0, aw_todo = 1, w_todo = 1, aw_hs, w_hs;
        int n = 0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while ((aw_todo || aw_pend || w_todo || w_pend) && n < 100) begin
            if (aw_todo && aw_dly == 0) begin aw_pend = 1; aw_todo = 0; end
            if (w_todo && w_dly == 0) begin w_pend = 1; w_todo = 0; end
            if (aw_todo && !w_todo && !w_pend) begin
                chk("w_early_wready", wready, 0);
                chk("w_early_noreq", mmio_req, 0);
            end
            if (w_todo && !aw_todo && !aw_pend) begin
                chk("aw_early_awready", awready, 0);
                chk("aw_early_noreq", mmio_req, 0);
            end
            awvalid = aw_pend;
            wvalid  = w_pend;
            aw_hs   = aw_pend && awready;
            w_hs    = w_pend && wready;
            if (aw_hs || w_hs) last_hs = cyc + 1;
            @(negedge clk);
            n++;
            if (aw_hs) aw_pend = 0;
            if (w_hs) w_pend = 0;
            if (aw_dly > 0) aw_dly--;
            if (w_dly > 0) w_dly--;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_accept", {28'd0, aw_todo, aw_pend, w_todo, w_pend}, 0);
    endtask

    task automatic axi_read(input logic [31:0] a);
        int n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", arready, 1);
        last_hs = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic axi_both(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d,
                            input logic [3:0] s);
        bit ar_p = 1, aw_p = 1, w_p = 1, ar_h, aw_h, w_h;
        int n = 0;
        araddr = ra;
        awaddr = wa;
        wdata  = d;
        wstrb  = s;
        while ((ar_p || aw_p || w_p) && n < 100) begin
            arvalid = ar_p;
            awvalid = aw_p;
            wvalid  = w_p;
            ar_h = ar_p && arready;
            aw_h = aw_p && awready;
            w_h  = w_p && wready;
            @(negedge clk);
            n++;
            if (ar_h) ar_p = 0;
            if (aw_h) aw_p = 0;
            if (w_h) w_p = 0;
        end
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("both_accept", {29'd0, ar_p, aw_p, w_p}, 0);
    endtask

    task automatic get_resp(input string nm, input int hold, output int lat);
        rsp_t        e;
        int          n = 0;
        bit          stable = 1;
        logic        ch0;
        logic [1:0]  r0;
        logic [31:0] d0;
        lat = -1;
        while (!bvalid && !rvalid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, {31'd0, bvalid | rvalid}, 1);
        if (!(bvalid || rvalid)) return;
        if (rsp_q.size() == 0) begin
            chk({nm, "_unexpected"}, 32'(rsp_q.size()), 1);
            return;
        end
        e   = rsp_q.pop_front();
        lat = cyc - last_hs;
        ch0 = bvalid;
        r0  = bvalid ? bresp : rresp;
        d0  = rdata;
        chk({nm, "_chan_is_wr"}, bvalid, e.is_wr);
        chk({nm, "_both_valid"}, bvalid & rvalid, 0);
        chk({nm, "_resp"}, r0, e.resp);
        if (!e.is_wr) chk({nm, "_rdata"}, d0, e.rdata);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (bvalid !== ch0 || (bvalid | rvalid) !== 1'b1) stable = 0;
            if ((ch0 ? bresp : rresp) !== r0 || rdata !== d0) stable = 0;
        end
        if (hold > 0) chk({nm, "_stable"}, stable, 1);
        if (ch0) bready = 1'b1;
        else rready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        rready = 1'b0;
        chk({nm, "_drop"}, bvalid | rvalid, 0);
        chk({nm, "_rdata_idle"}, rdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        vecs[0] = '{1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 32'h0, 0, 0};
        vecs[1] = '{1, 32'h2000_0010, 32'hDEAD_BEEF, 4'h3, 3, 2, 32'h0, 0, 1};
        vecs[2] = '{0, 32'h3000_0000, 32'h0, 4'h0, 0, 4, 32'h1234_5678, 1, 3};
        vecs[3] = '{0, 32'h0000_00FC, 32'h0, 4'h0, 0, 0, 32'hCAFE_F00D, 0, 0};
        vecs[4] = '{1, 32'hFFFF_FFFC, 32'h0000_0001, 4'h1, -2, 1, 32'h0, 1, 2};
        vecs[5] = '{0, 32'h8000_0040, 32'h0, 4'h0, 0, 0, 32'hFFFF_FFFF, 1, 1};

        rst_n = 1'b0;
        {awvalid, wvalid, arvalid, bready, rready} = '0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awprot = 3'b010; arprot = 3'b101;
        repeat (3) @(negedge clk);

        chk("rst_readies", {29'd0, awready, wready, arready}, 0);
        chk("rst_mmio_req", mmio_req, 0);
        chk("rst_valids", {30'd0, bvalid, rvalid}, 0);
        chk("rst_resp_data", {bresp, rresp, rdata[27:0]}, 0);
        rst_n = 1'b1;
        #1 chk("rel_readies_before_edge", {29'd0, awready, wready, arready}, 0);
        @(negedge clk);
        chk("rel_readies_after_edge", {29'd0, awready, wready, arready}, 3'b111);

        // Contended grants alternate: read first after reset, then write first.
        rsp_wait = 0; rsp_rdata = 32'h0BAD_F00D; rsp_err = 0;
        push_exp(0, 32'h4000_0000, 32'h0, 4'h0, 32'h0BAD_F00D, 0);
        push_exp(1, 32'h4000_0100, 32'h1111_2222, 4'hF, 32'h0, 0);
        axi_both(32'h4000_0000, 32'h4000_0100, 32'h1111_2222, 4'hF);
        get_resp("arb1_first", 0, lat);
        get_resp("arb1_second", 0, lat);
        rsp_rdata = 32'h3333_4444;
        push_exp(1, 32'h4000_0204, 32'h5555_6666, 4'hC, 32'h0, 0);
        push_exp(0, 32'h4000_0200, 32'h0, 4'h0, 32'h3333_4444, 0);
        axi_both(32'h4000_0200, 32'h4000_0204, 32'h5555_6666, 4'hC);
        get_resp("arb2_first", 0, lat);
        get_resp("arb2_second", 0, lat);

        for (int i = 0; i < 6; i++) begin
            rsp_wait  = vecs[i].wait_cyc;
            rsp_rdata = vecs[i].rdata;
            rsp_err   = vecs[i].err;
            r0 = rises;
            push_exp(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                     vecs[i].rdata, vecs[i].err);
            if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].lead);
            else axi_read(vecs[i].addr);
            get_resp($sformatf("vec%0d", i), vecs[i].hold, lat);
            chk($sformatf("vec%0d_req_latency", i), 32'(req_cyc - last_hs), 1);
            chk($sformatf("vec%0d_resp_latency", i), 32'(lat), 32'(2 + vecs[i].wait_cyc));
            chk($sformatf("vec%0d_single_req", i), 32'(rises - r0), 1);
        end

        // AR captured while a write is still waiting on MMIO, served afterwards.
        rsp_wait = 5; rsp_rdata = 32'h9999_0001; rsp_err = 0;
        push_exp(1, 32'h6000_0000, 32'h0102_0304, 4'hF, 32'h0, 0);
        push_exp(0, 32'h6000_0008, 32'h0, 4'h0, 32'h9999_0001, 0);
        axi_write(32'h6000_0000, 32'h0102_0304, 4'hF, 0);
        axi_read(32'h6000_0008);
        chk("overlap_arready_held", arready, 0);
        chk("overlap_no_rvalid", rvalid, 0);
        get_resp("overlap_wr", 0, lat);
        get_resp("overlap_rd", 0, lat);

        rsp_wait = 1000; rsp_rdata = 32'h5555_AAAA; rsp_err = 0;
`ifdef AXIL_MMIO_TIMEOUT_EN
        push_exp(0, 32'h7000_0000, 32'h0, 4'h0, 32'h0, 1);
        axi_read(32'h7000_0000);
        get_resp("tmo", 0, lat);
        chk("tmo_req_len", 32'(req_len), 8);
        chk("tmo_latency", 32'(lat), 9);
`else
        push_exp(0, 32'h7000_0000, 32'h0, 4'h0, 32'h5555_AAAA, 0);
        axi_read(32'h7000_0000);
        repeat (30) @(negedge clk);
        chk("notmo_req_held", mmio_req, 1);
        chk("notmo_no_rvalid", rvalid, 0);
        rsp_wait = 0;
        get_resp("notmo", 0, lat);
`endif

        // Reset in the middle of a write request.
        rsp_wait = 1000;
        push_exp(1, 32'h5000_0008, 32'h0F0F_0F0F, 4'hF, 32'h0, 0);
        axi_write(32'h5000_0008, 32'h0F0F_0F0F, 4'hF, 0);
        @(negedge clk);
        chk("mid_rst_req_before", mmio_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_async", mmio_req, 0);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_readies", {29'd0, awready, wready, arready}, 0);
        rsp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_readies", {29'd0, awready, wready, arready}, 3'b111);
        rsp_wait = 0; rsp_rdata = 32'h7777_0001; rsp_err = 0;
        push_exp(0, 32'h5000_0010, 32'h0, 4'h0, 32'h7777_0001, 0);
        axi_read(32'h5000_0010);
        get_resp("post_rst_rd", 0, lat);
        chk("post_rst_latency", 32'(lat), 2);

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(req_q.size() + rsp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
